// File: rtl/ul_agc_pkg.sv
// Shared types and helpers for the uplink AGC gain controller.
package ul_agc_pkg;

  localparam int MAG_W = 17;
  localparam int IDX_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACC     = 2'd1,
    CALC    = 2'd2,
    WAIT_HD = 2'd3
  } agc_state_e;

  // Move a gain index by one step, saturating at 0 and at max_idx.
  function automatic logic [IDX_W-1:0] sat_step(input logic [IDX_W-1:0] idx,
                                                input logic             dn,
                                                input logic [IDX_W-1:0] step,
                                                input logic [IDX_W-1:0] max_idx);
    logic [IDX_W:0] sum;
    sum = {1'b0, idx} + {1'b0, step};
    if (dn) begin
      sat_step = (idx >= step) ? idx - step : '0;
    end else begin
      sat_step = (sum > {1'b0, max_idx}) ? max_idx : sum[IDX_W-1:0];
    end
  endfunction

endpackage

// File: rtl/ul_agc_pwr_acc.sv
// Per-antenna |I|+|Q| accumulator and sample-count bank for the AGC window.
module ul_agc_pwr_acc
  import ul_agc_pkg::*;
#(
  parameter int XNUM     = 8,
  parameter int WIN_LOG2 = 10
) (
  input  logic                      clk_245,
  input  logic                      asy_rst,
  input  logic [31:0]               i_data,
  input  logic                      acc_en,
  input  logic                      clr,
  input  logic [2:0]                slot,
  input  logic [2:0]                rd_idx,
  output logic                      all_full,
  output logic [MAG_W+WIN_LOG2-1:0] acc_rd
);

  localparam int ACC_W = MAG_W + WIN_LOG2;

  logic [MAG_W-1:0]  abs_i, abs_q, mag;
  logic [ACC_W-1:0]  acc [XNUM];
  logic [WIN_LOG2:0] cnt [XNUM];
  logic [XNUM-1:0]   hit, full;

  // Negate in 17 bits so -32768 maps to 32768 without saturation.
  assign abs_i = i_data[31] ? MAG_W'(0) - {1'b1, i_data[31:16]} : {1'b0, i_data[31:16]};
  assign abs_q = i_data[15] ? MAG_W'(0) - {1'b1, i_data[15:0]}  : {1'b0, i_data[15:0]};
  assign mag   = abs_i + abs_q;

  always_comb begin
    hit  = '0;
    full = '0;
    for (int k = 0; k < XNUM; k++) begin
      hit[k]  = acc_en && (slot == 3'(k));
      full[k] = cnt[k][WIN_LOG2];
    end
  end

  assign all_full = &full;
  assign acc_rd   = acc[rd_idx];

  always_ff @(posedge clk_245 or posedge asy_rst) begin
    if (asy_rst) begin
      for (int k = 0; k < XNUM; k++) begin
        acc[k] <= '0;
        cnt[k] <= '0;
      end
    end else begin
      for (int k = 0; k < XNUM; k++) begin
        if (clr) begin
          acc[k] <= hit[k] ? ACC_W'(mag) : '0;
          cnt[k] <= hit[k] ? {{WIN_LOG2{1'b0}}, 1'b1} : '0;
        end else if (hit[k] && !full[k]) begin
          acc[k] <= acc[k] + ACC_W'(mag);
          cnt[k] <= cnt[k] + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ul_agc_gain_ctrl.sv
// Closed-loop per-antenna AGC index controller; publishes new indices on a frame head.
// Optional power report port enabled by `define UL_AGC_PWR_RPT_EN.
//   state   | meaning
//   IDLE    | loop off or awaiting first frame head
//   ACC     | accumulating the measurement window
//   CALC    | updating one antenna shadow index per cycle
//   WAIT_HD | shadow ready, publish on next frame head
module ul_agc_gain_ctrl
  import ul_agc_pkg::*;
#(
  parameter int XNUM     = 8,
  parameter int WIN_LOG2 = 10,
  parameter int MAX_IDX  = 255,
  parameter int STEP     = 1
) (
  input  logic        clk_245,
  input  logic        asy_rst,
  input  logic [31:0] i_data,
  input  logic        i_data_valid,
  input  logic        i_fram_hd,
  input  logic        i_agc_en,
  input  logic [16:0] i_target_mag,
  input  logic [15:0] i_hyst,
  input  logic [63:0] i_init_idx,
`ifdef UL_AGC_PWR_RPT_EN
  input  logic [2:0]  i_rpt_sel,
  output logic [16:0] o_pwr_rpt,
`endif
  output logic [31:0] o_a0_ddc_gain_lte,
  output logic [31:0] o_a1_ddc_gain_lte,
  output logic [31:0] o_a2_ddc_gain_lte,
  output logic [31:0] o_a3_ddc_gain_lte,
  output logic [31:0] o_a4_ddc_gain_lte,
  output logic [31:0] o_a5_ddc_gain_lte,
  output logic [31:0] o_a6_ddc_gain_lte,
  output logic [31:0] o_a7_ddc_gain_lte,
  output logic        o_upd_pulse
);

  localparam int ACC_W = MAG_W + WIN_LOG2;
  localparam int CW    = ACC_W + 1;

  agc_state_e       state, state_nxt;
  logic [2:0]       slot_cnt, cur_slot, calc_idx;
  logic             start, publish, acc_en, clr, all_full, go_up, go_dn;
  logic [ACC_W-1:0] acc_rd, avg_full;
  logic [IDX_W-1:0] shadow [8];
  logic [IDX_W-1:0] gain   [8];

  assign cur_slot = i_fram_hd ? 3'd0 : slot_cnt;
  assign start    = i_agc_en && i_fram_hd && (state == IDLE || state == WAIT_HD);
  assign publish  = i_agc_en && i_fram_hd && (state == WAIT_HD);
  // The frame-head sample that opens a window is slot 0 of that window.
  assign acc_en   = i_data_valid && i_agc_en && (state == ACC || start);
  assign clr      = !i_agc_en || start;

  ul_agc_pwr_acc #(.XNUM(XNUM), .WIN_LOG2(WIN_LOG2)) u_pwr_acc (
    .clk_245  (clk_245),
    .asy_rst  (asy_rst),
    .i_data   (i_data),
    .acc_en   (acc_en),
    .clr      (clr),
    .slot     (cur_slot),
    .rd_idx   (calc_idx),
    .all_full (all_full),
    .acc_rd   (acc_rd)
  );

  assign avg_full = acc_rd >> WIN_LOG2;
  assign go_dn    = CW'(avg_full) > CW'(i_target_mag) + CW'(i_hyst);
  assign go_up    = CW'(avg_full) + CW'(i_hyst) < CW'(i_target_mag);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_fram_hd) state_nxt = ACC;
      ACC:     if (all_full) state_nxt = CALC;
      CALC:    if (calc_idx == 3'(XNUM-1)) state_nxt = WAIT_HD;
      WAIT_HD: if (i_fram_hd) state_nxt = ACC;
      default: state_nxt = IDLE;
    endcase
    if (!i_agc_en) state_nxt = IDLE;
  end

  always_ff @(posedge clk_245 or posedge asy_rst) begin
    if (asy_rst) begin
      state    <= IDLE;
      slot_cnt <= '0;
      calc_idx <= '0;
    end else begin
      state    <= state_nxt;
      slot_cnt <= (cur_slot == 3'(XNUM-1)) ? 3'd0 : cur_slot + 1'b1;
      calc_idx <= (state == CALC) ? calc_idx + 1'b1 : 3'd0;
    end
  end

  always_ff @(posedge clk_245 or posedge asy_rst) begin
    if (asy_rst) begin
      o_upd_pulse <= 1'b0;
      for (int k = 0; k < 8; k++) begin
        shadow[k] <= '0;
        gain[k]   <= '0;
      end
    end else begin
      o_upd_pulse <= publish;
      if (!i_agc_en) begin
        for (int k = 0; k < XNUM; k++) begin
          shadow[k] <= i_init_idx[8*k +: 8];
          gain[k]   <= i_init_idx[8*k +: 8];
        end
      end else begin
        if (state == CALC && (go_up || go_dn))
          shadow[calc_idx] <= sat_step(shadow[calc_idx], go_dn, IDX_W'(STEP), IDX_W'(MAX_IDX));
        if (publish) begin
          for (int k = 0; k < XNUM; k++) gain[k] <= shadow[k];
        end
      end
    end
  end

`ifdef UL_AGC_PWR_RPT_EN
  logic [MAG_W-1:0] avg_q [8];

  // Averages survive loop disable so the report keeps the last measurement.
  always_ff @(posedge clk_245 or posedge asy_rst) begin
    if (asy_rst) begin
      o_pwr_rpt <= '0;
      for (int k = 0; k < 8; k++) avg_q[k] <= '0;
    end else begin
      if (state == CALC) avg_q[calc_idx] <= avg_full[MAG_W-1:0];
      o_pwr_rpt <= avg_q[i_rpt_sel];
    end
  end
`endif

  assign o_a0_ddc_gain_lte = {{(32-IDX_W){1'b0}}, gain[0]};
  assign o_a1_ddc_gain_lte = {{(32-IDX_W){1'b0}}, gain[1]};
  assign o_a2_ddc_gain_lte = {{(32-IDX_W){1'b0}}, gain[2]};
  assign o_a3_ddc_gain_lte = {{(32-IDX_W){1'b0}}, gain[3]};
  assign o_a4_ddc_gain_lte = {{(32-IDX_W){1'b0}}, gain[4]};
  assign o_a5_ddc_gain_lte = {{(32-IDX_W){1'b0}}, gain[5]};
  assign o_a6_ddc_gain_lte = {{(32-IDX_W){1'b0}}, gain[6]};
  assign o_a7_ddc_gain_lte = {{(32-IDX_W){1'b0}}, gain[7]};

endmodule

// File: tb/tb_ul_agc_gain_ctrl.sv
// Scoreboard bench for ul_agc_gain_ctrl: expected publishes are queued at stimulus time.
module tb_ul_agc_gain_ctrl;

  localparam int FRAME = 160;

  logic        clk_245 = 1'b0;
  logic        asy_rst = 1'b1;
  logic [31:0] i_data = '0;
  logic        i_data_valid = 1'b0;
  logic        i_fram_hd = 1'b0;
  logic        i_agc_en = 1'b0;
  logic [16:0] i_target_mag = 17'd2000;
  logic [15:0] i_hyst = 16'd100;
  logic [63:0] i_init_idx = '0;
  logic [31:0] o_a0_ddc_gain_lte, o_a1_ddc_gain_lte, o_a2_ddc_gain_lte, o_a3_ddc_gain_lte;
  logic [31:0] o_a4_ddc_gain_lte, o_a5_ddc_gain_lte, o_a6_ddc_gain_lte, o_a7_ddc_gain_lte;
  logic        o_upd_pulse;
`ifdef UL_AGC_PWR_RPT_EN
  logic [2:0]  i_rpt_sel = '0;
  logic [16:0] o_pwr_rpt;
`endif

  always #5 clk_245 = ~clk_245;

  ul_agc_gain_ctrl #(.WIN_LOG2(4)) dut (
    .clk_245           (clk_245),
    .asy_rst           (asy_rst),
    .i_data            (i_data),
    .i_data_valid      (i_data_valid),
    .i_fram_hd         (i_fram_hd),
    .i_agc_en          (i_agc_en),
    .i_target_mag      (i_target_mag),
    .i_hyst            (i_hyst),
    .i_init_idx        (i_init_idx),
`ifdef UL_AGC_PWR_RPT_EN
    .i_rpt_sel         (i_rpt_sel),
    .o_pwr_rpt         (o_pwr_rpt),
`endif
    .o_a0_ddc_gain_lte (o_a0_ddc_gain_lte),
    .o_a1_ddc_gain_lte (o_a1_ddc_gain_lte),
    .o_a2_ddc_gain_lte (o_a2_ddc_gain_lte),
    .o_a3_ddc_gain_lte (o_a3_ddc_gain_lte),
    .o_a4_ddc_gain_lte (o_a4_ddc_gain_lte),
    .o_a5_ddc_gain_lte (o_a5_ddc_gain_lte),
    .o_a6_ddc_gain_lte (o_a6_ddc_gain_lte),
    .o_a7_ddc_gain_lte (o_a7_ddc_gain_lte),
    .o_upd_pulse       (o_upd_pulse)
  );

  logic [31:0] a_out [8];
  assign a_out[0] = o_a0_ddc_gain_lte;
  assign a_out[1] = o_a1_ddc_gain_lte;
  assign a_out[2] = o_a2_ddc_gain_lte;
  assign a_out[3] = o_a3_ddc_gain_lte;
  assign a_out[4] = o_a4_ddc_gain_lte;
  assign a_out[5] = o_a5_ddc_gain_lte;
  assign a_out[6] = o_a6_ddc_gain_lte;
  assign a_out[7] = o_a7_ddc_gain_lte;

  logic [63:0] exp_q [$];
  logic [63:0] exp_v;
  int          n_chk = 0;
  int          n_fail = 0;
  int          iv [8];
  int          qv [8];
  logic        vhalf = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  task automatic chk_all(input string name, input logic [63:0] req);
    for (int k = 0; k < 8; k++)
      chk($sformatf("%s a%0d", name, k), a_out[k], {24'h0, req[8*k +: 8]});
  endtask

  // Monitor: every publish pulse consumes one expected index vector.
  always @(negedge clk_245) begin
    if (o_upd_pulse === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_pulse: got a publish pulse, want none");
      end else begin
        exp_v = exp_q.pop_front();
        chk_all("publish", exp_v);
      end
    end
  end

  task automatic set_pat(input int m0, input int m1, input int m2, input int m3,
                         input int m4, input int m5, input int m6, input int m7);
    int m [8];
    m = '{m0, m1, m2, m3, m4, m5, m6, m7};
    for (int k = 0; k < 8; k++) begin
      iv[k] = m[k] / 2;
      qv[k] = m[k] - m[k] / 2;
    end
  endtask

  task automatic phase_setup(input logic [63:0] init);
    @(posedge clk_245); #1;
    i_agc_en = 1'b0;
    i_fram_hd = 1'b0;
    i_data_valid = 1'b0;
    i_init_idx = init;
    repeat (3) @(posedge clk_245);
    #1;
    chk_all("manual_load", init);
    chk("manual_load pulse", {31'h0, o_upd_pulse}, 32'h0);
    i_agc_en = 1'b1;
  endtask

  task automatic run_frame(input int drop_at, input int rst_at, input logic [63:0] drop_init);
    logic [31:0] ti, tq;
    for (int c = 0; c < FRAME; c++) begin
      @(posedge clk_245); #1;
      ti = iv[c % 8];
      tq = qv[c % 8];
      i_fram_hd    = (c == 0);
      i_data_valid = vhalf ? (((c >> 3) % 2) == 0) : 1'b1;
      i_data       = {ti[15:0], tq[15:0]};
      if (c == drop_at) begin
        i_agc_en   = 1'b0;
        i_init_idx = drop_init;
      end
      if (drop_at >= 0 && c == drop_at + 1) begin
        chk_all("agc_off", drop_init);
        chk("agc_off pulse", {31'h0, o_upd_pulse}, 32'h0);
      end
      if (c == rst_at) begin
        asy_rst = 1'b1;
        #1;
        chk_all("async_reset", 64'h0);
        chk("async_reset pulse", {31'h0, o_upd_pulse}, 32'h0);
      end
      if (rst_at >= 0 && c == rst_at + 3) asy_rst = 1'b0;
    end
  endtask

  task automatic phase_end(input string name);
    repeat (2) @(posedge clk_245);
    #1;
    chk({name, " pending"}, 32'(exp_q.size()), 32'h0);
    exp_q.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    #23;
    chk_all("reset", 64'h0);
    chk("reset pulse", {31'h0, o_upd_pulse}, 32'h0);
    @(posedge clk_245); #1;
    asy_rst = 1'b0;

    // steady state at target: indices hold
    set_pat(2000, 2000, 2000, 2000, 2000, 2000, 2000, 2000);
    phase_setup({8{8'h40}});
    repeat (2) exp_q.push_back({8{8'h40}});
    repeat (3) run_frame(-1, -1, 64'h0);
    phase_end("steady");

    // antenna 3 too hot: steps down once per window
    set_pat(2000, 2000, 2000, 4000, 2000, 2000, 2000, 2000);
    phase_setup({8{8'h40}});
    exp_q.push_back({8'h40, 8'h40, 8'h40, 8'h40, 8'h3F, 8'h40, 8'h40, 8'h40});
    exp_q.push_back({8'h40, 8'h40, 8'h40, 8'h40, 8'h3E, 8'h40, 8'h40, 8'h40});
    exp_q.push_back({8'h40, 8'h40, 8'h40, 8'h40, 8'h3D, 8'h40, 8'h40, 8'h40});
    repeat (4) run_frame(-1, -1, 64'h0);
    phase_end("ant3_down");

    // floor at 0 for loud antennas, increment for quiet ones
    set_pat(4000, 4000, 4000, 4000, 100, 100, 100, 100);
    phase_setup(64'h0);
    exp_q.push_back({8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00});
    exp_q.push_back({8'h02, 8'h02, 8'h02, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00});
    repeat (3) run_frame(-1, -1, 64'h0);
    phase_end("floor");

    // ceiling at MAX_IDX for quiet antennas
    set_pat(100, 100, 100, 100, 100, 100, 100, 4000);
    phase_setup({8{8'hFF}});
    exp_q.push_back({8'hFE, {7{8'hFF}}});
    exp_q.push_back({8'hFD, {7{8'hFF}}});
    repeat (3) run_frame(-1, -1, 64'h0);
    phase_end("ceiling");

    // hysteresis edges and full-scale magnitudes
    iv = '{1050, 1051, 950, 950, -32768, -1000, 0, 32767};
    qv = '{1050, 1050, 950, 949, -32768, 1000, -2000, -32768};
    phase_setup({8{8'h40}});
    exp_q.push_back({8'h3F, 8'h40, 8'h40, 8'h3F, 8'h41, 8'h40, 8'h3F, 8'h40});
    repeat (2) run_frame(-1, -1, 64'h0);
    phase_end("boundary");

    // 50% valid: windows span two frames, same index trajectory
    set_pat(2000, 2000, 2000, 4000, 2000, 2000, 2000, 2000);
    vhalf = 1'b1;
    phase_setup({8{8'h40}});
    exp_q.push_back({8'h40, 8'h40, 8'h40, 8'h40, 8'h3F, 8'h40, 8'h40, 8'h40});
    exp_q.push_back({8'h40, 8'h40, 8'h40, 8'h40, 8'h3E, 8'h40, 8'h40, 8'h40});
    repeat (5) run_frame(-1, -1, 64'h0);
    phase_end("half_valid");
    vhalf = 1'b0;

    // loop disabled during CALC: manual load, no publish afterwards
    phase_setup({8{8'h40}});
    run_frame(132, -1, {8{8'h22}});
    run_frame(-1, -1, 64'h0);
    phase_end("agc_off");

    // async reset mid-window, restart from the next frame head
    set_pat(100, 2000, 2000, 2000, 2000, 2000, 2000, 2000);
    phase_setup({8{8'h40}});
    exp_q.push_back(64'h01);
    run_frame(-1, 50, 64'h0);
    repeat (2) run_frame(-1, -1, 64'h0);
    phase_end("async_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
